// File: rtl/regfile_sb_if.sv
// Bundle of decode/write-back signals for the scoreboarded register file.
// The master side is the pipeline; the slave side is the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]         srcA;
  logic [ID_W-1:0]         srcB;
  logic [DATA_W-1:0]       valA;
  logic [DATA_W-1:0]       valB;
  logic                    busyA;
  logic                    busyB;
  logic [ID_W-1:0]         dstE;
  logic [DATA_W-1:0]       valE;
  logic [ID_W-1:0]         dstM;
  logic [DATA_W-1:0]       valM;
  logic                    claim_valid;
  logic [ID_W-1:0]         claim_id;
  logic                    claim_ready;
  logic [NREGS*DATA_W-1:0] regs_flat;

  modport master (
    output srcA, srcB, dstE, valE, dstM, valM, claim_valid, claim_id,
    input  valA, valB, busyA, busyB, claim_ready, regs_flat
  );

  modport slave (
    input  srcA, srcB, dstE, valE, dstM, valM, claim_valid, claim_id,
    output valA, valB, busyA, busyB, claim_ready, regs_flat
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-through bypass and a
// per-register count of in-flight writes for RAW hazard detection.
module regfile_sb #(
  parameter int              DATA_W  = 64,
  parameter int              NREGS   = 15,
  parameter int              ID_W    = 4,
  parameter logic [ID_W-1:0] NONE_ID = '1,
  parameter int              CNT_W   = 2,
  parameter bit              BYPASS  = 1'b1
) (
  input logic         clock,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];
  logic              we_e;
  logic              we_m;
  logic [NREGS-1:0]  ret;
  logic [NREGS-1:0]  clm;
  logic              rdy;

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (32'(id) < NREGS) && (id != NONE_ID);
  endfunction

  // M overrides E on a shared destination, matching the storage priority.
  function automatic logic [DATA_W-1:0] rd_val(input logic [ID_W-1:0] src);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++)
      if (id_ok(src) && src == ID_W'(i)) v = regs[i];
    if (BYPASS) begin
      if (we_m && bus.dstM == src)      v = bus.valM;
      else if (we_e && bus.dstE == src) v = bus.valE;
    end
    if (!reset) v = '0;
    return v;
  endfunction

  function automatic logic rd_busy(input logic [ID_W-1:0] src);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (id_ok(src) && src == ID_W'(i)) b = (cnt[i] != '0);
    return b && reset;
  endfunction

  always_comb begin
    we_e = reset && id_ok(bus.dstE);
    we_m = reset && id_ok(bus.dstM);
    ret  = '0;
    clm  = '0;
    rdy  = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      ret[i] = (we_e && bus.dstE == ID_W'(i)) || (we_m && bus.dstM == ID_W'(i));
      if (id_ok(bus.claim_id) && bus.claim_id == ID_W'(i))
        rdy = (cnt[i] != CNT_MAX) || ret[i];
    end
    if (!reset) rdy = 1'b0;
    for (int i = 0; i < NREGS; i++)
      clm[i] = bus.claim_valid && rdy && id_ok(bus.claim_id) && bus.claim_id == ID_W'(i);
  end

  always_comb begin
    bus.valA        = rd_val(bus.srcA);
    bus.valB        = rd_val(bus.srcB);
    bus.busyA       = rd_busy(bus.srcA);
    bus.busyB       = rd_busy(bus.srcB);
    bus.claim_ready = rdy;
  end

  // A simultaneous claim and retire cancel; retiring an idle register saturates at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_e && bus.dstE == ID_W'(i)) regs[i] <= bus.valE;
        if (we_m && bus.dstM == ID_W'(i)) regs[i] <= bus.valM;
        if (clm[i] && !ret[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (ret[i] && !clm[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign bus.regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with write-through bypass and a per-register pending-write scoreboard. It generalises the processor register file in data width, register count and ID width. It adds in-flight write tracking so the pipelined decode stage can detect RAW hazards. It sits between decode (read ports, claims) and write-back (E/M write ports).

## Interface
Parameters:
- DATA_W, 64, register width in bits
- NREGS, 15, number of architectural registers (IDs 0..NREGS-1)
- ID_W, 4, register ID width; requires NREGS <= 2^ID_W - 1
- NONE_ID, 4'hF (all ones of ID_W), "no register" ID
- CNT_W, 2, pending-count width per register
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- srcA, srcB  in  ID_W  read IDs
- valA, valB  out  DATA_W  read data
- busyA, busyB  out  1  the addressed register has pending writes
- dstE  in  ID_W  E write ID; NONE_ID = no write
- valE  in  DATA_W  E write data
- dstM  in  ID_W  M write ID; NONE_ID = no write
- valM  in  DATA_W  M write data
- claim_valid  in  1  decode reserves a future write
- claim_id  in  ID_W  register being reserved
- claim_ready  out  1  reservation can be accepted this cycle
- regs_flat  out  NREGS*DATA_W  all register contents, register i at bits [i*DATA_W +: DATA_W]

## Operation
- Storage: NREGS registers of DATA_W bits, plus NREGS counters cnt[i] of CNT_W bits.
- Valid ID: less than NREGS and not NONE_ID. Writes, claims and reads using an invalid ID are ignored; reads of an invalid ID return 0 and busy=0.
- Write: on a clock edge, register dstE is loaded with valE and register dstM is loaded with valM. If dstE == dstM, valM wins.
- Read: combinational. With BYPASS=1, a read of a register being written this cycle returns the incoming data, with the M port taking priority over E. With BYPASS=0, the read returns the stored value.
- Scoreboard: a handshake is a claim_valid && claim_ready cycle with a valid claim_id. It increments cnt[claim_id].
- A retire is a valid write on E or M. It decrements cnt of that register by 1. If E and M target the same register, cnt still decrements by only 1.
- Claim and retire of the same register in the same cycle leave cnt unchanged.
- Retire at cnt == 0: the data write still happens and cnt stays 0 (no underflow).
- claim_ready = 1 when cnt[claim_id] != 2^CNT_W - 1, or when a retire of claim_id happens in the same cycle. For an invalid claim_id, claim_ready = 1 and the claim is a no-op.
- busyA = (cnt[srcA] != 0) from registered state only; a same-cycle retire does not clear it. busyB is defined the same way for srcB.

## Timing
- While reset is low: all registers and cnt are cleared asynchronously; valA=valB=0; busyA=busyB=0; claim_ready=0; regs_flat=0. Writes, claims and bypass are suppressed.
- When reset deasserts, the first active clock edge can perform writes and claims.
- Write latency: 1 edge. With BYPASS=1 the read-after-write latency is 0 cycles; with BYPASS=0 it is 1 cycle.
- A claimed register shows busy from the edge after the claim handshake.
- busy drops on the edge at which the last retire is registered.
- Reset asserted mid-operation wipes all pending counts; there is no recovery of in-flight claims.

## Test plan
- Reset, then write valE=64'h1234 with dstE=3; the same cycle, read srcA=3. Required: valA=64'h1234 with BYPASS=1; with BYPASS=0, valA=0 this cycle and 64'h1234 the next.
- dstE=dstM=4, valE=5, valM=9. Required: reg4=9; cnt[4] drops by 1 only.
- Claim reg 2 three times with CNT_W=2. Required: cnt[2]=3, claim_ready=0 for id 2. A claim and a retire of reg 2 in the same cycle are accepted and cnt stays 3.
- Retire reg 6 with cnt[6]=0. Required: data written, cnt stays 0, busy stays 0.
- Access invalid IDs: read srcA=NONE_ID, and with NREGS=15, dstE=15 and claim_id=15. Required: valA=0, busyA=0, no register changes, claim_ready=1.
- Assert reset mid-stream with cnt[1]=2 and reg1=7. Required: immediately busy=0, valA=0, claim_ready=0; after release, reg1 reads 0.
